// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit multicycle CPU: word width, fetch FSM
// state encoding and the sequential PC increment.
package cpu_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } fetch_state_t;

  localparam logic [15:0] PC_INCR = 16'd1;

endpackage

// File: rtl/fetch_watchdog.sv
// Counts consecutive stalled REQ cycles; expired is asserted combinationally
// during the LIMIT-th stalled cycle so the fetch FSM can abandon the read.
module fetch_watchdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (count_en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = count_en && (count_reg == CW'(LIMIT - 1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: reads memory at PC, latches IR, hands it to decode
// and drives the PC register. Optional fetch timeout under FETCH_TIMEOUT_EN.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int WORD_W                  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_en,
  input  logic [WORD_W-1:0] PC,
  output logic              readM,
  output logic [WORD_W-1:0] address,
  input  logic [WORD_W-1:0] mem_data,
  input  logic              input_ready,
  output logic [WORD_W-1:0] IR,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_target,
  output logic [WORD_W-1:0] next_PC,
  output logic              PCwrite,
  output logic              fetch_err
);

  fetch_state_t      state_reg, state_next;
  logic [WORD_W-1:0] ir_reg, ir_next;
  logic              pend_valid_reg, pend_valid_next;
  logic [WORD_W-1:0] pend_target_reg, pend_target_next;
  logic [WORD_W-1:0] pc_incr;
  logic              expired;
  logic              err_next;

  assign pc_incr = PC + WORD_W'(PC_INCR);

`ifdef FETCH_TIMEOUT_EN
  fetch_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    ((state_reg != REQ) || input_ready),
    .count_en ((state_reg == REQ) && !input_ready),
    .expired  (expired)
  );
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES != 0);
  assign expired        = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      ir_reg          <= '0;
      pend_valid_reg  <= 1'b0;
      pend_target_reg <= '0;
    end else begin
      state_reg       <= state_next;
      ir_reg          <= ir_next;
      pend_valid_reg  <= pend_valid_next;
      pend_target_reg <= pend_target_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    ir_next          = ir_reg;
    pend_valid_next  = pend_valid_reg;
    pend_target_next = pend_target_reg;
    PCwrite          = 1'b0;
    next_PC          = pc_incr;
    err_next         = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (redirect_valid) begin
          PCwrite = 1'b1;
          next_PC = redirect_target;
        end
        if (fetch_en) state_next = REQ;
      end

      REQ: begin
        if (input_ready) begin
          PCwrite = 1'b1;
          if (redirect_valid || pend_valid_reg) begin
            // Word was fetched from the stale path: drop it and refetch.
            next_PC         = redirect_valid ? redirect_target : pend_target_reg;
            pend_valid_next = 1'b0;
            state_next      = fetch_en ? REQ : IDLE;
          end else begin
            ir_next    = mem_data;
            state_next = VALID;
          end
        end else if (expired) begin
          err_next        = 1'b1;
          state_next      = IDLE;
          pend_valid_next = 1'b0;
          if (redirect_valid) begin
            PCwrite = 1'b1;
            next_PC = redirect_target;
          end else if (pend_valid_reg) begin
            PCwrite = 1'b1;
            next_PC = pend_target_reg;
          end
        end else if (redirect_valid) begin
          pend_valid_next  = 1'b1;
          pend_target_next = redirect_target;
        end
      end

      VALID: begin
        if (redirect_valid) begin
          PCwrite    = 1'b1;
          next_PC    = redirect_target;
          state_next = fetch_en ? REQ : IDLE;
        end else if (ir_ready) begin
          state_next = fetch_en ? REQ : IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign readM     = (state_reg == REQ);
  assign ir_valid  = (state_reg == VALID);
  assign address   = PC;
  assign IR        = ir_reg;
  assign fetch_err = err_next;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural PC register and a
// hand-timed memory; add FETCH_TIMEOUT_EN to also cover the timeout path.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_en;
  logic [15:0] PC;
  logic        readM;
  logic [15:0] address;
  logic [15:0] mem_data;
  logic        input_ready;
  logic [15:0] IR;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic [15:0] next_PC;
  logic        PCwrite;
  logic        fetch_err;

  logic        pc_set;
  logic [15:0] pc_set_val;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_fetch #(
    .WORD_W(16),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fetch_en       (fetch_en),
    .PC             (PC),
    .readM          (readM),
    .address        (address),
    .mem_data       (mem_data),
    .input_ready    (input_ready),
    .IR             (IR),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .next_PC        (next_PC),
    .PCwrite        (PCwrite),
    .fetch_err      (fetch_err)
  );

  // PC register the fetch stage sits beside; pc_set lets the bench preload it.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)     PC <= 16'h0000;
    else if (pc_set)  PC <= pc_set_val;
    else if (PCwrite) PC <= next_PC;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one clock; inputs are then driven at posedge+2 and checked at posedge+3.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    input_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 16'h0000;
    mem_data        = 16'h0000;
    pc_set          = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    fetch_en = 1'b0;
    ir_ready = 1'b0;
    pc_set_val = 16'h0000;
    idle_inputs();
    #13;
    check("rst_readM", readM, 0);
    check("rst_ir_valid", ir_valid, 0);
    check("rst_IR", IR, 16'h0000);
    check("rst_PCwrite", PCwrite, 0);
    check("rst_fetch_err", fetch_err, 0);
    reset_n = 1'b1;

    // Basic fetch: 0x1234 returned in the third REQ cycle.
    tick(); fetch_en = 1'b1; #1;
    check("idle_readM", readM, 0);
    tick(); #1;
    check("req1_readM", readM, 1);
    check("req1_address", address, 16'h0000);
    tick(); #1;
    check("req2_readM", readM, 1);
    check("req2_PCwrite", PCwrite, 0);
    tick(); input_ready = 1'b1; mem_data = 16'h1234; #1;
    check("req3_readM", readM, 1);
    check("req3_PCwrite", PCwrite, 1);
    check("req3_next_PC", next_PC, 16'h0001);
    tick(); idle_inputs(); #1;
    check("valid_ir_valid", ir_valid, 1);
    check("valid_IR", IR, 16'h1234);
    check("valid_PC", PC, 16'h0001);

    // Decode stall for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin tick(); #1; end
      check($sformatf("stall%0d_ir_valid", i), ir_valid, 1);
      check($sformatf("stall%0d_IR", i), IR, 16'h1234);
      check($sformatf("stall%0d_readM", i), readM, 0);
      check($sformatf("stall%0d_PCwrite", i), PCwrite, 0);
    end
    tick(); ir_ready = 1'b1; #1;
    check("accept_PCwrite", PCwrite, 0);
    tick(); #1;
    check("refetch_readM", readM, 1);
    check("refetch_address", address, 16'h0001);
    check("refetch_ir_valid", ir_valid, 0);
    input_ready = 1'b1; mem_data = 16'h5555; #1;
    check("fetch2_next_PC", next_PC, 16'h0002);
    tick(); idle_inputs(); #1;
    check("fetch2_IR", IR, 16'h5555);

    // Wrap-around from 0xFFFF.
    tick(); pc_set = 1'b1; pc_set_val = 16'hFFFF; #1;
    check("wrap_req_readM", readM, 1);
    tick(); pc_set = 1'b0; input_ready = 1'b1; mem_data = 16'h7777; #1;
    check("wrap_address", address, 16'hFFFF);
    check("wrap_PCwrite", PCwrite, 1);
    check("wrap_next_PC", next_PC, 16'h0000);
    tick(); idle_inputs(); #1;
    check("wrap_IR", IR, 16'h7777);
    check("wrap_PC", PC, 16'h0000);

    // Redirect to 0x0040 while the read is outstanding.
    tick(); redirect_valid = 1'b1; redirect_target = 16'h0040; #1;
    check("rdreq_readM", readM, 1);
    check("rdreq_PCwrite", PCwrite, 0);
    tick(); idle_inputs(); input_ready = 1'b1; mem_data = 16'hDEAD; #1;
    check("rdreq_resp_PCwrite", PCwrite, 1);
    check("rdreq_resp_next_PC", next_PC, 16'h0040);
    tick(); idle_inputs(); #1;
    check("rdreq_new_readM", readM, 1);
    check("rdreq_new_address", address, 16'h0040);
    check("rdreq_ir_valid", ir_valid, 0);
    check("rdreq_IR_kept", IR, 16'h7777);

    // Redirect in VALID coinciding with ir_ready.
    input_ready = 1'b1; mem_data = 16'h2222; #1;
    check("f40_next_PC", next_PC, 16'h0041);
    tick(); idle_inputs(); #1;
    check("f40_IR", IR, 16'h2222);
    redirect_valid = 1'b1; redirect_target = 16'h0100; #1;
    check("rdval_PCwrite", PCwrite, 1);
    check("rdval_next_PC", next_PC, 16'h0100);
    tick(); idle_inputs(); #1;
    check("rdval_readM", readM, 1);
    check("rdval_address", address, 16'h0100);
    check("rdval_ir_valid", ir_valid, 0);

    // Incoming redirect beats the pending one.
    redirect_valid = 1'b1; redirect_target = 16'h0200; #1;
    tick(); input_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 16'h0300; #1;
    check("prio_next_PC", next_PC, 16'h0300);
    tick(); idle_inputs(); #1;
    check("prio_address", address, 16'h0300);
    check("prio_readM", readM, 1);

    // fetch_en falls mid-read: complete, deliver, then park in IDLE.
    fetch_en = 1'b0;
    tick(); #1;
    check("fen_readM", readM, 1);
    input_ready = 1'b1; mem_data = 16'h3333; #1;
    check("fen_next_PC", next_PC, 16'h0301);
    tick(); idle_inputs(); #1;
    check("fen_IR", IR, 16'h3333);
    check("fen_ir_valid", ir_valid, 1);
    tick(); #1;
    check("fen_idle_readM", readM, 0);
    check("fen_idle_ir_valid", ir_valid, 0);

    // Redirects from IDLE.
    redirect_valid = 1'b1; redirect_target = 16'h0500; #1;
    check("idle_rd_PCwrite", PCwrite, 1);
    check("idle_rd_next_PC", next_PC, 16'h0500);
    tick(); idle_inputs(); #1;
    check("idle_rd_stay_readM", readM, 0);
    check("idle_rd_PC", PC, 16'h0500);
    fetch_en = 1'b1; redirect_valid = 1'b1; redirect_target = 16'h0600; #1;
    tick(); idle_inputs(); #1;
    check("idle_rd2_readM", readM, 1);
    check("idle_rd2_address", address, 16'h0600);
    check("no_err_default", fetch_err, 0);

    // Asynchronous reset mid-read, then a late response.
    reset_n = 1'b0; fetch_en = 1'b0; #1;
    check("arst_readM", readM, 0);
    tick(); input_ready = 1'b1; mem_data = 16'hBEEF; #1;
    reset_n = 1'b1;
    tick(); idle_inputs(); #1;
    check("arst_ir_valid", ir_valid, 0);
    check("arst_IR", IR, 16'h0000);
    check("arst_readM_after", readM, 0);

`ifdef FETCH_TIMEOUT_EN
    // Four stalled REQ cycles, error on the fourth, then IDLE with PC held.
    fetch_en = 1'b1;
    tick(); #1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("to_req%0d_readM", i), readM, 1);
      check($sformatf("to_req%0d_fetch_err", i), fetch_err, (i == 4) ? 1 : 0);
      check($sformatf("to_req%0d_PCwrite", i), PCwrite, 0);
      tick(); #1;
    end
    check("to_idle_readM", readM, 0);
    check("to_idle_fetch_err", fetch_err, 0);
    check("to_PC", PC, 16'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage for the 16-bit multicycle CPU. It sits directly beside the PC register: it reads the current PC, issues a memory read at that address, and latches the returned word into the instruction register. It then hands the instruction to decode with a valid/ready handshake. It also computes `next_PC` and the `PCwrite` strobe that advance or redirect the PC register.

## Interface
- `WORD_W`, 16, instruction/address width.
- `TIMEOUT_CYCLES`, 255, maximum REQ cycles before a fetch error (used only with `FETCH_TIMEOUT_EN`).

- `clk`  in  1  single clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `fetch_en`  in  1  core run enable; fetching starts or continues only while high.
- `PC`  in  16  current PC from the PC register.
- `readM`  out  1  memory read request.
- `address`  out  16  memory address; equals `PC` combinationally.
- `mem_data`  in  16  memory read data; valid when `input_ready`=1.
- `input_ready`  in  1  memory response strobe; one cycle per read.
- `IR`  out  16  registered instruction.
- `ir_valid`  out  1  `IR` holds an undelivered instruction.
- `ir_ready`  in  1  decode accepts `IR`.
- `redirect_valid`  in  1  branch/jump taken (single-cycle pulse).
- `redirect_target`  in  16  new PC for the redirect.
- `next_PC`  out  16  value loaded into the PC register.
- `PCwrite`  out  1  PC load strobe; combinational, one cycle per update.
- `fetch_err`  out  1  one-cycle pulse on fetch timeout.

## Operation
- FSM states: IDLE, REQ, VALID. Reset state is IDLE.
- Reset values: `readM`=0, `IR`=0x0000, `ir_valid`=0, `PCwrite`=0, `fetch_err`=0. The pending-redirect flag and target are cleared.
- `readM`=1 exactly in REQ. `ir_valid`=1 exactly in VALID.
- IDLE: when `fetch_en`=1, go to REQ.
- REQ, `input_ready`=1, no redirect (pending or this cycle):
  - `IR`<=`mem_data`.
  - `PCwrite`=1, `next_PC`=`PC`+1, computed modulo 2^16 (0xFFFF wraps to 0x0000).
  - Go to VALID.
- REQ, `redirect_valid`=1 without `input_ready`:
  - Latch `redirect_target` into the pending-redirect register.
  - A later redirect overwrites the pending one.
- REQ, `input_ready`=1 with a redirect pending or arriving this cycle:
  - Discard `mem_data`; `IR` is unchanged.
  - `PCwrite`=1, `next_PC`=target. An incoming target takes priority over the pending one.
  - Clear the pending redirect.
  - Go to REQ if `fetch_en`=1, otherwise IDLE.
- VALID, `ir_ready`=1 and no redirect: go to REQ if `fetch_en`=1, otherwise IDLE.
- VALID, `redirect_valid`=1:
  - Drop `IR`; `ir_valid` falls next cycle, and the handshake is void even if `ir_ready`=1.
  - `PCwrite`=1, `next_PC`=`redirect_target`.
  - Go to REQ if `fetch_en`=1, otherwise IDLE.
- IDLE, `redirect_valid`=1: `PCwrite`=1, `next_PC`=`redirect_target`; the `fetch_en` rule applies.
- `fetch_en` falling during REQ does not abort the read. The FSM completes the read, then stops in VALID or IDLE.
- `input_ready` outside REQ is ignored.
- When `PCwrite`=0, `next_PC`=`PC`+1 (don't-care to the consumer).

## Timing
- Memory latency is arbitrary, ≥1 cycle after `readM` rises.
- Redirect-to-new-request: 1 cycle. From IDLE or VALID, `readM` rises in the cycle after `redirect_valid`, with `address` = target.
- Fetch latency: the cycle after the `input_ready` cycle has `ir_valid`=1, `IR`=data, and `PC` already advanced.
- Back-to-back fetch: with `ir_ready` held at 1, the minimum per-instruction period is 1 (REQ) + memory latency + 1 (VALID).
- Asynchronous reset mid-read immediately forces IDLE and `readM`=0. A late `input_ready` after reset is ignored.

## Configuration
- Macro: `FETCH_TIMEOUT_EN`.
- Defined:
  - A cycle counter runs in REQ.
  - After `TIMEOUT_CYCLES` consecutive REQ cycles with no `input_ready`, pulse `fetch_err` for one cycle and go to IDLE.
  - `PC` is unchanged, unless a redirect is pending; in that case `PCwrite`=1, `next_PC`=pending target, and the pending redirect is cleared.
  - The counter clears on entry to REQ.
- Undefined: no counter exists, `fetch_err` is tied to 0, and REQ waits indefinitely.

## Structure
- Shared package `cpu_pkg`: `WORD_W`, FSM state enum `fetch_state_t` (IDLE, REQ, VALID), and constant `PC_INCR`=16'd1.
- One sub-module, `fetch_watchdog`: timeout counter with inputs `clk`, `reset_n`, `clear`, `count_en` and output `expired`. It is instantiated only under `FETCH_TIMEOUT_EN`.

## Test plan
- Basic fetch: reset, `PC`=0x0000, `fetch_en`=1; memory returns 0x1234 after 2 cycles. Expect `readM`=1 for 3 cycles, `PCwrite` pulse with `next_PC`=0x0001, then `IR`=0x1234 and `ir_valid`=1.
- Stall: hold `ir_ready`=0 for 5 cycles. Expect `ir_valid`=1 and `IR` stable, no `readM`, and no `PCwrite` until `ir_ready`=1.
- Wrap-around: `PC`=0xFFFF with a normal fetch. Expect `next_PC`=0x0000.
- Redirect mid-read: `redirect_valid` with target 0x0040 while in REQ, before `input_ready`. Expect the returned word discarded, `PCwrite` with `next_PC`=0x0040, `IR` unchanged, `ir_valid`=0, and a new REQ at 0x0040.
- Redirect in VALID, same cycle as `ir_ready`=1: target 0x0100. Expect `IR` dropped, `next_PC`=0x0100, and REQ next cycle.
- Reset and timeout: assert `reset_n`=0 during REQ and expect `readM`=0 immediately. With `FETCH_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, never respond; expect a `fetch_err` pulse after 4 REQ cycles, then IDLE with `PC` unchanged.
